// File: rtl/fpu_pkg.sv
// ============================================================================
//  Module   : fpu_pkg
//  Brief    : Shared types and helpers for the parametrised FP add/sub unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package fpu_pkg;

  typedef enum logic [3:0] {
    EXACT     = 4'b0001,
    INEXACT   = 4'b0010,
    OVERFLOW  = 4'b0100,
    UNDERFLOW = 4'b1000
  } status_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ALIGN     = 3'd1,
    CALC      = 3'd2,
    NORMALIZE = 3'd3,
    ROUND     = 3'd4,
    PACK      = 3'd5
  } state_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_lzc.sv
// ============================================================================
//  Module   : fpu_lzc
//  Brief    : Combinational leading-zero counter; all-zero input yields W.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_lzc #(
  parameter  int W     = 28,
  localparam int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_value,
  output logic [CNT_W-1:0] o_count
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    o_count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (i_value[i]) begin
        o_count = CNT_W'(W - 1 - i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_addsub_param.sv
// ============================================================================
//  Module   : fpu_addsub_param
//  Brief    : Multi-cycle parametrised FP add/sub, RNE rounding, saturating
//             overflow and flush-to-zero underflow; fixed 5-clock latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_addsub_param
  import fpu_pkg::*;
#(
  parameter  int EXP_W  = 7,
  parameter  int MAN_W  = 24,
  localparam int DATA_W = 1 + EXP_W + MAN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] op_A_in,
  input  logic [DATA_W-1:0] op_B_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        status_out
);

  localparam int c_SIG_W     = MAN_W + 1;
  localparam int c_EXT_W     = MAN_W + 4;
  localparam int c_SE_W      = EXP_W + 2;
  localparam int c_SH_W      = $clog2(c_EXT_W);
  localparam int c_LZ_W      = $clog2(c_EXT_W + 1);
  localparam int c_MAX_SHIFT = MAN_W + 3;
  localparam logic signed [c_SE_W-1:0] c_EXP_MAX = c_SE_W'((1 << EXP_W) - 1);
  localparam logic signed [c_SE_W-1:0] c_EXP_ONE = c_SE_W'(1);

  state_t                    r_state;
  logic                      r_sign_a, r_sign_b;
  logic [EXP_W-1:0]          r_exp_a, r_exp_b;
  logic [c_SIG_W-1:0]        r_sig_a, r_sig_b;
  logic                      r_sign_l, r_sign_s;
  logic [c_EXT_W-1:0]        r_big, r_small;
  logic [c_EXT_W:0]          r_sum;
  logic [c_EXT_W-1:0]        r_norm;
  logic                      r_sign;
  logic signed [c_SE_W-1:0]  r_exp;
  logic                      r_zero;
  logic [DATA_W-1:0]         r_result;
  logic [3:0]                r_status;

  logic                      w_a_larger;
  logic [EXP_W-1:0]          w_exp_diff;
  logic [c_SIG_W-1:0]        w_sig_small;
  logic [c_SH_W-1:0]         w_shift;
  logic [c_EXT_W-1:0]        w_small_ext, w_shifted, w_aligned;
  logic                      w_sticky;
  logic [c_LZ_W-1:0]         w_lzc;
  logic                      w_inc, w_lost;
  logic [c_SIG_W:0]          w_mant;
  logic [MAN_W-1:0]          w_frac;
  logic signed [c_SE_W-1:0]  w_exp_r;
  logic [DATA_W-1:0]         w_result;
  logic [3:0]                w_status;

  // Alignment: exponent then significand decides the larger magnitude.
  always_comb begin
    w_a_larger  = {r_exp_a, r_sig_a} >= {r_exp_b, r_sig_b};
    w_exp_diff  = w_a_larger ? (r_exp_a - r_exp_b) : (r_exp_b - r_exp_a);
    w_sig_small = w_a_larger ? r_sig_b : r_sig_a;
    w_shift     = (int'(w_exp_diff) > c_MAX_SHIFT) ? c_SH_W'(c_MAX_SHIFT)
                                                   : c_SH_W'(w_exp_diff);
    w_small_ext = {w_sig_small, 3'b000};
    w_shifted   = w_small_ext >> w_shift;
    w_sticky    = |(w_small_ext & ~({c_EXT_W{1'b1}} << w_shift));
    w_aligned   = {w_shifted[c_EXT_W-1:1], w_shifted[0] | w_sticky};
  end

  fpu_lzc #(.W(c_EXT_W)) u_lzc (
    .i_value (r_sum[c_EXT_W-1:0]),
    .o_count (w_lzc)
  );

  // Rounding and range checks; bits [2:0] of r_norm are G, R, S.
  always_comb begin
    w_inc  = r_norm[2] & (r_norm[1] | r_norm[0] | r_norm[3]);
    w_lost = |r_norm[2:0];
    w_mant = {1'b0, r_norm[c_EXT_W-1:3]} + {{c_SIG_W{1'b0}}, w_inc};
    if (w_mant[c_SIG_W]) begin
      w_frac  = w_mant[MAN_W:1];
      w_exp_r = r_exp + c_EXP_ONE;
    end else begin
      w_frac  = w_mant[MAN_W-1:0];
      w_exp_r = r_exp;
    end
    w_result = '0;
    w_status = EXACT;
    if (r_zero) begin
      w_result = '0;
      w_status = w_lost ? INEXACT : EXACT;
    end else if (w_exp_r > c_EXP_MAX) begin
      w_result = {r_sign, {(DATA_W-1){1'b1}}};
      w_status = OVERFLOW | INEXACT;
    end else if (w_exp_r[c_SE_W-1] || (w_exp_r == '0)) begin
      w_result = {r_sign, {(DATA_W-1){1'b0}}};
      w_status = UNDERFLOW | INEXACT;
    end else begin
      w_result = {r_sign, w_exp_r[EXP_W-1:0], w_frac};
      w_status = w_lost ? INEXACT : EXACT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_exp_a    <= '0;
      r_exp_b    <= '0;
      r_sig_a    <= '0;
      r_sig_b    <= '0;
      r_sign_l   <= 1'b0;
      r_sign_s   <= 1'b0;
      r_big      <= '0;
      r_small    <= '0;
      r_sum      <= '0;
      r_norm     <= '0;
      r_sign     <= 1'b0;
      r_exp      <= '0;
      r_zero     <= 1'b0;
      r_result   <= '0;
      r_status   <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign_a <= op_A_in[DATA_W-1];
            r_sign_b <= op_B_in[DATA_W-1] ^ op;
            r_exp_a  <= op_A_in[DATA_W-2:MAN_W];
            r_exp_b  <= op_B_in[DATA_W-2:MAN_W];
            // A zero exponent encodes zero regardless of the fraction field.
            r_sig_a  <= (op_A_in[DATA_W-2:MAN_W] == '0) ? '0 : {1'b1, op_A_in[MAN_W-1:0]};
            r_sig_b  <= (op_B_in[DATA_W-2:MAN_W] == '0) ? '0 : {1'b1, op_B_in[MAN_W-1:0]};
            busy     <= 1'b1;
            r_state  <= ALIGN;
          end
        end
        ALIGN: begin
          r_sign_l <= w_a_larger ? r_sign_a : r_sign_b;
          r_sign_s <= w_a_larger ? r_sign_b : r_sign_a;
          r_exp    <= {2'b00, (w_a_larger ? r_exp_a : r_exp_b)};
          r_big    <= {(w_a_larger ? r_sig_a : r_sig_b), 3'b000};
          r_small  <= w_aligned;
          r_state  <= CALC;
        end
        CALC: begin
          if (r_sign_l == r_sign_s) begin
            r_sum <= {1'b0, r_big} + {1'b0, r_small};
          end else begin
            r_sum <= {1'b0, r_big} - {1'b0, r_small};
          end
          r_sign  <= r_sign_l;
          r_state <= NORMALIZE;
        end
        NORMALIZE: begin
          r_zero <= (r_sum == '0);
          if (r_sum == '0) begin
            r_sign <= 1'b0;
          end
          if (r_sum[c_EXT_W]) begin
            r_norm <= {r_sum[c_EXT_W:2], r_sum[1] | r_sum[0]};
            r_exp  <= r_exp + c_EXP_ONE;
          end else begin
            r_norm <= r_sum[c_EXT_W-1:0] << w_lzc;
            r_exp  <= r_exp - c_SE_W'(w_lzc);
          end
          r_state <= ROUND;
        end
        ROUND: begin
          r_result <= w_result;
          r_status <= w_status;
          r_state  <= PACK;
        end
        PACK: begin
          data_out   <= r_result;
          status_out <= r_status;
          done       <= 1'b1;
          busy       <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_addsub_param.sv
// ============================================================================
//  Module   : tb_fpu_addsub_param
//  Brief    : Directed scoreboard bench for the FP add/sub unit (EXP_W=7, MAN_W=24).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fpu_addsub_param;
  import fpu_pkg::*;

  localparam logic [31:0] c_ONE = 32'(bias(7)) << 24;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_A_in = '0;
  logic [31:0] op_B_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;

  int n_cmp = 0;
  int n_fail = 0;
  logic [35:0] sb_q[$];

  fpu_addsub_param #(.EXP_W(7), .MAN_W(24)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .op_A_in    (op_A_in),
    .op_B_in    (op_B_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // respin: cycle index k at whose edge a second start is presented (0 = none)
  task automatic run_op(input string tag, input logic o, input logic [31:0] a, b,
                        input logic [31:0] exp_d, input logic [3:0] exp_s, input int respin);
    int dones;
    int lat;
    logic [35:0] e;
    dones = 0;
    lat = 0;
    sb_q.push_back({exp_d, exp_s});
    @(negedge clock);
    op = o; op_A_in = a; op_B_in = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k == respin) begin
        start = 1'b1;
        op_A_in = 32'h7FFFFFFF;
      end
      @(posedge clock);
      #1 start = 1'b0;
      if (k == 1) check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
      if (done) begin
        dones++;
        if (dones == 1) begin
          lat = k;
          check($sformatf("%s_busy_at_done", tag), 32'(busy), 32'd0);
          check($sformatf("%s_sb_depth", tag), sb_q.size(), 32'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check($sformatf("%s_data", tag), data_out, e[35:4]);
            check($sformatf("%s_status", tag), 32'(status_out), 32'(e[3:0]));
          end
        end
      end
    end
    check($sformatf("%s_latency", tag), lat, 32'd5);
    check($sformatf("%s_done_count", tag), dones, 32'd1);
    check($sformatf("%s_hold", tag), data_out, exp_d);
  endtask

  initial begin
    int seen;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_status", 32'(status_out), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op("one_plus_one",  1'b0, c_ONE, c_ONE, 32'h40000000, 4'b0001, 0);
    run_op("one_minus_one", 1'b1, c_ONE, c_ONE, 32'h00000000, 4'b0001, 0);
    run_op("tie_even",      1'b0, c_ONE, 32'h26000000, 32'h3F000000, 4'b0010, 0);
    run_op("round_up",      1'b0, c_ONE, 32'h26800000, 32'h3F000001, 4'b0010, 0);
    run_op("overflow",      1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0110, 0);
    run_op("underflow",     1'b1, 32'h01800000, 32'h01000000, 32'h00000000, 4'b1010, 0);
    run_op("two_minus_one", 1'b1, 32'h40000000, c_ONE, 32'h3F000000, 4'b0001, 0);
    run_op("neg_result",    1'b1, c_ONE, 32'h40000000, 32'hBF000000, 4'b0001, 0);
    run_op("zero_operand",  1'b0, 32'h00123456, 32'h3F800000, 32'h3F800000, 4'b0001, 0);
    run_op("shift_sat",     1'b0, c_ONE, 32'h01000000, 32'h3F000000, 4'b0010, 0);
    run_op("mant_carry",    1'b0, 32'h3FFFFFFF, 32'h26800000, 32'h40000000, 4'b0010, 0);
    run_op("start_ignored", 1'b0, c_ONE, c_ONE, 32'h40000000, 4'b0001, 2);

    // Abort mid-operation with reset asserted just after E3.
    @(negedge clock);
    op = 1'b1; op_A_in = 32'h40000000; op_B_in = c_ONE; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_data", data_out, 32'd0);
    check("abort_status", 32'(status_out), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 32'd0);

    run_op("after_abort", 1'b1, 32'h40000000, c_ONE, 32'h3F000000, 4'b0001, 0);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
